// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM state encoding and default width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared one-bit-per-cycle engine: shift-add unsigned multiply and restoring unsigned divide.
// o_lo/o_hi present the accumulator after the current step; they are final while o_fin=1.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_go,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_fin
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_run;
  logic [CW-1:0]      r_cnt;

  logic [2*WIDTH-1:0] w_next;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;

  // One iteration step; the divide compare needs WIDTH+1 bits because the shifted remainder can reach 2*b-1
  always_comb begin
    w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_opb};
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_next = {w_add, r_acc[WIDTH-1:1]};
    end
  end

  assign o_lo  = w_next[WIDTH-1:0];
  assign o_hi  = w_next[2*WIDTH-1:WIDTH];
  assign o_fin = r_run & (r_cnt == CNT_LAST);

  // Operand capture on go, then one accumulator step per cycle until the last count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= {(2*WIDTH){1'b0}};
      r_opb    <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_run    <= 1'b0;
      r_cnt    <= {CW{1'b0}};
    end else if (i_go) begin
      r_acc    <= {{WIDTH{1'b0}}, i_a};
      r_opb    <= i_b;
      r_is_div <= i_is_div;
      r_run    <= 1'b1;
      r_cnt    <= {CW{1'b0}};
    end else if (r_run) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + CW'(1);
      if (o_fin) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/done handshake: single-cycle logic/arith/shift ops plus
// iterative MULTU/DIVU into a HI/LO pair. All results and flags are registered.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_gin,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_zout,
  output logic             o_ovf,
  output logic             o_dz
);

  state_t           r_state;
  logic             r_busy, r_done, r_zout, r_ovf, r_dz;
  logic [WIDTH-1:0] r_sum, r_hi;

  state_t           w_state_nx;
  logic             w_accept, w_multi, w_go, w_fin;
  logic [WIDTH-1:0] w_res, w_res_hi, w_add, w_sub, w_it_lo, w_it_hi;
  logic             w_ovf, w_dz;
  logic [SHW-1:0]   w_shamt;

  assign w_add   = i_a + i_b;
  assign w_sub   = i_a - i_b;
  assign w_shamt = i_b[SHW-1:0];

  // Single-cycle result selection; ovf is the signed overflow of the add/sub seen by the operand signs
  always_comb begin
    w_res    = {WIDTH{1'b0}};
    w_res_hi = {WIDTH{1'b0}};
    w_ovf    = 1'b0;
    w_dz     = 1'b0;
    w_multi  = 1'b0;
    case (i_gin)
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_NOR:  w_res = ~(i_a | i_b);
      OP_XOR:  w_res = i_a ^ i_b;
      OP_ADD: begin
        w_res = w_add;
        w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) & (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub;
        w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) & (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_SLL:  w_res = i_a << w_shamt;
      OP_SRL:  w_res = i_a >> w_shamt;
      OP_SRA:  w_res = $signed(i_a) >>> w_shamt;
      OP_MULTU: w_multi = 1'b1;
      OP_DIVU: begin
        if (i_b == {WIDTH{1'b0}}) begin
          w_res    = {WIDTH{1'b1}};
          w_res_hi = i_a;
          w_dz     = 1'b1;
        end else begin
          w_multi = 1'b1;
        end
      end
      default: w_res = {WIDTH{1'b0}};
    endcase
  end

  assign w_accept = i_start & (r_state != ST_RUN);
  assign w_go     = w_accept & w_multi;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_go     (w_go),
    .i_is_div (i_gin == OP_DIVU),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_lo     (w_it_lo),
    .o_hi     (w_it_hi),
    .o_fin    (w_fin)
  );

  // Next-state logic; a DONE cycle behaves like IDLE so back-to-back accepts are possible
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nx = w_multi ? ST_RUN : ST_DONE;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_fin) begin
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_RUN;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State, handshake and result registers; results change only on the edge that enters DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_zout  <= 1'b1;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx == ST_RUN);
      r_done  <= (w_state_nx == ST_DONE);
      if (w_accept && !w_multi) begin
        r_sum  <= w_res;
        r_hi   <= w_res_hi;
        r_zout <= ~|w_res;
        r_ovf  <= w_ovf;
        r_dz   <= w_dz;
      end else if ((r_state == ST_RUN) && w_fin) begin
        r_sum  <= w_it_lo;
        r_hi   <= w_it_hi;
        r_zout <= ~|w_it_lo;
        r_ovf  <= 1'b0;
        r_dz   <= 1'b0;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_hi   = r_hi;
  assign o_zout = r_zout;
  assign o_ovf  = r_ovf;
  assign o_dz   = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): vector table through a scoreboard queue,
// plus hand-written reset-abort, busy-ignore and back-to-back sequences.
module tb_alu_seq;

  localparam int W = 32;

  typedef struct {
    logic [3:0]   gin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic [W-1:0] hi;
    logic         ovf;
    logic         dz;
    int           lat;
  } vec_t;

  logic         clk, rst_n, start;
  logic [3:0]   gin;
  logic [W-1:0] a, b;
  logic         busy, done, zout, ovf, dz;
  logic [W-1:0] sum, hi;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb[$];
  vec_t vecs[20];

  alu_seq #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_gin   (gin),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_hi    (hi),
    .o_zout  (zout),
    .o_ovf   (ovf),
    .o_dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] g, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] es, input logic [W-1:0] eh,
                              input logic eo, input logic ed, input int el);
    vec_t v;
    v.gin = g; v.a = va; v.b = vb; v.sum = es; v.hi = eh; v.ovf = eo; v.dz = ed; v.lat = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"},  64'(sum),  64'(e.sum));
      chk({tag, "_hi"},   64'(hi),   64'(e.hi));
      chk({tag, "_zout"}, 64'(zout), 64'(e.sum == '0));
      chk({tag, "_ovf"},  64'(ovf),  64'(e.ovf));
      chk({tag, "_dz"},   64'(dz),   64'(e.dz));
    end
  endtask

  // Issue one op, scramble inputs, wait (bounded) for done; optionally pulse start at cycle 5
  task automatic run_vec(input vec_t v, input string tag, input bit inject);
    int cyc;
    int busy_cnt;
    logic [W-1:0] held;
    @(negedge clk);
    start = 1'b1; gin = v.gin; a = v.a; b = v.b;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0; gin = 4'b0010; a = ~v.a; b = ~v.b;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cnt++;
      start = inject && (cyc == 5);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(v.lat - 1));
    if (done) check_out(tag);
    held = sum;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_held"}, 64'(sum), 64'(held));
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0; start = 1'b0; gin = 4'b0000; a = '0; b = '0;

    vecs[0]  = mk(4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1'b0, 1);
    vecs[1]  = mk(4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 1'b0, 1'b0, 1);
    vecs[2]  = mk(4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1);
    vecs[3]  = mk(4'b1000, 32'h80000000, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b0, 1);
    vecs[4]  = mk(4'b1100, 32'hF0000000, 32'h00000004, 32'hFF000000, 32'h0, 1'b0, 1'b0, 1);
    vecs[5]  = mk(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1);
    vecs[6]  = mk(4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1'b0, 1);
    vecs[7]  = mk(4'b0011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1);
    vecs[8]  = mk(4'b1001, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0, 1);
    vecs[9]  = mk(4'b1010, 32'h00000001, 32'h00000023, 32'h00000008, 32'h0, 1'b0, 1'b0, 1);
    vecs[10] = mk(4'b1011, 32'h80000000, 32'h0000001F, 32'h00000001, 32'h0, 1'b0, 1'b0, 1);
    vecs[11] = mk(4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, 1);
    vecs[12] = mk(4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b0, 1);
    vecs[13] = mk(4'b0100, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0, 1'b0, 1'b0, 1);
    vecs[14] = mk(4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h0, 1'b0, 1'b0, 1);
    vecs[15] = mk(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
    vecs[16] = mk(4'b1110, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33);
    vecs[17] = mk(4'b1110, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b1, 1);
    vecs[18] = mk(4'b1101, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 1'b0, 33);
    vecs[19] = mk(4'b1110, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0, 33);

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  64'(sum),  64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_zout", 64'(zout), 64'd1);
    chk("rst_ovf",  64'(ovf),  64'd0);
    chk("rst_dz",   64'(dz),   64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
    end

    // Start pulsed while busy must be dropped, not queued
    run_vec(vecs[15], "busy_ignore", 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("busy_ignore_no_extra_done", 64'(done), 64'd0);
    end

    // Reset during MULTU aborts with no later done
    @(negedge clk);
    start = 1'b1; gin = 4'b1101; a = 32'h00000003; b = 32'h00000005;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum",  64'(sum),  64'd0);
    chk("abort_zout", 64'(zout), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    start = 1'b1; gin = 4'b0010; a = 32'd3; b = 32'd4;
    sb.push_back(mk(4'b0010, 32'd3, 32'd4, 32'd7, 32'd0, 1'b0, 1'b0, 1));
    @(negedge clk);
    chk("b2b_done1", 64'(done), 64'd1);
    check_out("b2b_add");
    gin = 4'b0001; a = 32'h000000F0; b = 32'h0000000F;
    sb.push_back(mk(4'b0001, 32'hF0, 32'h0F, 32'hFF, 32'd0, 1'b0, 1'b0, 1));
    @(negedge clk);
    chk("b2b_done2", 64'(done), 64'd1);
    check_out("b2b_or");
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done_end", 64'(done), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
